scaler_h: RTL

- Horizontal linear-interpolation scaler; sits directly downstream of the vertical scaler and consumes its do_o/de_o/hs_o/vs_o stream.
- Each input line is written into a ping-pong line buffer. The previous line is read out and resampled at step scale_step (input pixel pitch = LINE_STEP).
- The output stream uses the same de/hs/vs pulse convention as the input, ready for a monitor or a further stage.

---
 rtl/scaler_h.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/scaler_h.sv
// Horizontal linear-interpolation scaler with a ping-pong line buffer.
// Latency: first de_o 3 cycles after the read machine starts, which is 1 cycle after the line's last pixel write.
// Backpressure: none; if a line completes while both banks are occupied, the queued line is dropped and err_o latches.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   line_in_size             input pixels per line minus 1
//   scale_step               output pitch (LINE_STEP = identity)
//   di_i/de_i/hs_i/vs_i      input pixel stream (hs_i precedes or coincides with the first de_i)
//   do_o/de_o/hs_o/vs_o      output pixel stream; hs_o/vs_o only ever asserted with de_o
//   err_o                    sticky overflow flag
// Optional macro SCALER_H_ROUND_EN: adds LINE_STEP/2 before the final shift (round to nearest);
// when it is undefined the result is truncated. Latency is the same either way.
module scaler_h #(
  parameter int LINE_IN_SIZE_MAX = 1024,
  parameter int LINE_STEP        = 128,
  parameter int PIXEL_WIDTH      = 8,
  parameter int SPARSE_OUT       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            line_in_size,
  input  logic [15:0]            scale_step,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   err_o
);

  localparam int L2  = $clog2(LINE_STEP);
  localparam int AW  = $clog2(LINE_IN_SIZE_MAX);
  localparam int PSW = 16 + L2 + 1;
  localparam int NW  = PSW - L2;
  localparam int MW  = PIXEL_WIDTH + L2 + 1;
  localparam int GW  = $clog2(SPARSE_OUT + 1) + 1;

`ifdef SCALER_H_ROUND_EN
  localparam logic [MW-1:0] RND = MW'(LINE_STEP / 2);
`else
  localparam logic [MW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t state, state_nx;

  logic [PIXEL_WIDTH-1:0] mem [2][LINE_IN_SIZE_MAX];

  // write side
  logic [15:0] wcnt, widx;
  logic        wb, wactive, wvs;
  logic [1:0]  full, vsp;
  logic        new_bank, wsel, wact_eff, we, wdone, line_vs;

  // read side
  logic            rb, first;
  logic [PSW-1:0]  pos, pos_nx;
  logic [15:0]     step;
  logic [NW-1:0]   n0, n1, n_nx;
  logic            last;
  logic [GW-1:0]   gcnt;
  logic            can0, can1, can_oth, ld, ld_bank, issue, free;

  // pipeline
  logic                   s1_vld, s1_hs, s1_vs;
  logic [L2-1:0]          s1_f;
  logic [PIXEL_WIDTH-1:0] s1_p0, s1_p1;
  logic                   s2_vld, s2_hs, s2_vs;
  logic [MW-1:0]          m0, m1;

  always_comb begin
    // A new line never lands in the bank being read; with the reader idle,
    // avoid a bank that is full and about to be picked up.
    new_bank = (state != IDLE) ? ~rb : full[0];
    wsel     = hs_i ? new_bank : wb;
    wact_eff = hs_i | wactive;
    widx     = hs_i ? 16'd0 : wcnt;
    we       = de_i & (hs_i | (wactive & (wcnt <= line_in_size)));
    wdone    = we & (widx == line_in_size);
    line_vs  = hs_i ? vs_i : wvs;
  end

  always_comb begin
    pos_nx = pos + PSW'(step);
    n0     = NW'(pos >> L2);
    n_nx   = NW'(pos_nx >> L2);
    last   = n_nx > NW'(line_in_size);
    n1     = (n0 >= NW'(line_in_size)) ? n0 : n0 + NW'(1);
    // A bank still being (over)written is not eligible for readout yet.
    can0    = full[0] & ~(wact_eff & (wsel == 1'b0));
    can1    = full[1] & ~(wact_eff & (wsel == 1'b1));
    can_oth = rb ? can0 : can1;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_bank  = 1'b0;
    issue    = 1'b0;
    free     = 1'b0;
    case (state)
      IDLE: begin
        if (can0) begin
          ld = 1'b1; ld_bank = 1'b0; state_nx = RUN;
        end else if (can1) begin
          ld = 1'b1; ld_bank = 1'b1; state_nx = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (last) begin
          free = 1'b1;
          if (can_oth) begin
            ld = 1'b1; ld_bank = ~rb; state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end else if (SPARSE_OUT > 0) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (int'(gcnt) == SPARSE_OUT - 1) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wcnt    <= '0;
      wb      <= 1'b0;
      wactive <= 1'b0;
      wvs     <= 1'b0;
      full    <= '0;
      vsp     <= '0;
      err_o   <= 1'b0;
      rb      <= 1'b0;
      first   <= 1'b0;
      pos     <= '0;
      step    <= 16'd1;
      gcnt    <= '0;
      s1_vld  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_f    <= '0;
      s2_vld  <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
      m0      <= '0;
      m1      <= '0;
      do_o    <= '0;
      de_o    <= 1'b0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs_i) begin
        wactive <= 1'b1;
        wb      <= new_bank;
        wvs     <= vs_i;
        wcnt    <= '0;
      end
      if (we) wcnt <= widx + 16'd1;
      if (wdone) wactive <= 1'b0;
      if (free) full[rb] <= 1'b0;
      if (wdone) begin
        full[wsel] <= 1'b1;
        vsp[wsel]  <= line_vs;
        // Completing into a bank that still holds an unread line loses that line.
        if (full[wsel]) err_o <= 1'b1;
      end
      if (ld) begin
        rb    <= ld_bank;
        pos   <= '0;
        step  <= (scale_step == 16'd0) ? 16'd1 : scale_step;
        first <= 1'b1;
      end else if (issue) begin
        pos   <= pos_nx;
        first <= 1'b0;
      end
      gcnt <= (state == GAP) ? gcnt + GW'(1) : '0;
      s1_vld <= issue;
      s1_hs  <= issue & first;
      s1_vs  <= issue & first & vsp[rb];
      s1_f   <= pos[L2-1:0];
      s2_vld <= s1_vld;
      s2_hs  <= s1_hs;
      s2_vs  <= s1_vs;
      m0     <= MW'(s1_p0) * (MW'(LINE_STEP) - MW'(s1_f));
      m1     <= MW'(s1_p1) * MW'(s1_f);
      de_o   <= s2_vld;
      hs_o   <= s2_hs;
      vs_o   <= s2_vs;
      do_o   <= PIXEL_WIDTH'((m0 + m1 + RND) >> L2);
    end
  end

  // Line buffer: one write port, two registered read ports (p0 and its right neighbour).
  always_ff @(posedge clk) begin
    if (we) mem[wsel][AW'(widx)] <= di_i;
    s1_p0 <= mem[rb][AW'(n0)];
    s1_p1 <= mem[rb][AW'(n1)];
  end

endmodule
